// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encodings seen on the state port.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      RST_HOLD = 3'd0,
      RUN      = 3'd1,
      HALTED   = 3'd2,
      ERROR    = 3'd3,
      TIMEOUT  = 3'd4
   } state_t;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases rst_ok two clk edges after rst rises.
module rst_sync (
   input  logic clk,
   input  logic rst,
   output logic rst_ok
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta   <= 1'b0;
         rst_ok <= 1'b0;
      end else begin
         meta   <= 1'b1;
         rst_ok <= meta;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: holds the core in reset, runs it, and latches a terminal status
// on halt, error or cycle-limit timeout until a clr restart.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 100000,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             err,
   input  logic             halt,
   input  logic             clr,
   output logic             core_rst,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [2:0]       state,
   output logic             done,
   output logic             fail
);

   localparam int               HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

   state_t        st;
   logic [HW-1:0] hold_cnt;
   logic          rst_ok;

   rst_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rst_ok (rst_ok)
   );

   assign state = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= RST_HOLD;
         core_rst  <= 1'b1;
         core_en   <= 1'b0;
         cycle_cnt <= '0;
         done      <= 1'b0;
         fail      <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         case (st)
            RST_HOLD: begin
               if (rst_ok) begin
                  if (hold_cnt == HOLD_LAST) begin
                     st       <= RUN;
                     core_rst <= 1'b0;
                     core_en  <= 1'b1;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
            end
            RUN: begin
               if (clr) begin
                  st        <= RST_HOLD;
                  core_rst  <= 1'b1;
                  core_en   <= 1'b0;
                  cycle_cnt <= '0;
                  hold_cnt  <= '0;
               end else begin
                  // the cycle on which a stop condition is seen still counts
                  cycle_cnt <= cycle_cnt + CNT_W'(1);
                  if (err) begin
                     st      <= ERROR;
                     core_en <= 1'b0;
                     done    <= 1'b1;
                     fail    <= 1'b1;
                  end else if (halt) begin
                     st      <= HALTED;
                     core_en <= 1'b0;
                     done    <= 1'b1;
                  end else if (cycle_cnt == CNT_LAST) begin
                     st      <= TIMEOUT;
                     core_en <= 1'b0;
                     done    <= 1'b1;
                     fail    <= 1'b1;
                  end
               end
            end
            HALTED, ERROR, TIMEOUT: begin
               if (clr) begin
                  st        <= RST_HOLD;
                  core_rst  <= 1'b1;
                  core_en   <= 1'b0;
                  cycle_cnt <= '0;
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            default: begin
               st        <= RST_HOLD;
               core_rst  <= 1'b1;
               core_en   <= 1'b0;
               cycle_cnt <= '0;
               done      <= 1'b0;
               fail      <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus randomized runs; terminal status is checked
// by a scoreboard monitor that fires whenever done rises.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int RSTC = 2;
   localparam int MAXC = 24;
   localparam int W    = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         err = 1'b0;
   logic         halt = 1'b0;
   logic         clr = 1'b0;
   logic         core_rst, core_en, done, fail;
   logic [W-1:0] cycle_cnt;
   logic [2:0]   state;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [2:0]   st;
      logic [W-1:0] cnt;
      logic         fl;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic done_q = 1'b0;

   run_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .err       (err),
      .halt      (halt),
      .clr       (clr),
      .core_rst  (core_rst),
      .core_en   (core_en),
      .cycle_cnt (cycle_cnt),
      .state     (state),
      .done      (done),
      .fail      (fail)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic exp_t mk(logic [2:0] s, int c, logic f);
      mk.st  = s;
      mk.cnt = W'(c);
      mk.fl  = f;
   endfunction

   // scoreboard monitor: a completion is whatever the DUT shows on the cycle done rises
   always @(negedge clk) begin
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected: done rose in state %0d, nothing expected", state);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_state", 32'(state), 32'(mon_e.st));
            chk("sb_cnt", cycle_cnt, mon_e.cnt);
            chk("sb_fail", 32'(fail), 32'(mon_e.fl));
            chk("sb_core_en", 32'(core_en), 0);
         end
      end
      done_q <= done;
   end

   task automatic release_seq(string tag);
      rst = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         chk({tag, "_core_rst"}, 32'(core_rst), (e < 4) ? 1 : 0);
      end
      chk({tag, "_state"}, 32'(state), 32'(RUN));
      chk({tag, "_core_en"}, 32'(core_en), 1);
      chk({tag, "_cnt"}, cycle_cnt, 0);
   endtask

   task automatic wait_run(string tag);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (state == RUN) break;
      end
      chk({tag, "_reach_run"}, 32'(state), 32'(RUN));
   endtask

   task automatic wait_done(string tag);
      for (int i = 0; i < MAXC + 40; i++) begin
         if (done) break;
         @(posedge clk); #1;
      end
      chk({tag, "_done"}, 32'(done), 1);
   endtask

   task automatic restart(string tag);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk({tag, "_clr_state"}, 32'(state), 32'(RST_HOLD));
      chk({tag, "_clr_cnt"}, cycle_cnt, 0);
      chk({tag, "_clr_done"}, 32'(done), 0);
      chk({tag, "_clr_core_rst"}, 32'(core_rst), 1);
      wait_run(tag);
   endtask

   // Starts just after the edge that entered RUN; flags are applied on the (k+1)th RUN edge.
   task automatic run_one(string tag, int k, bit e, bit h, bit c);
      exp_t x;
      bit   restarted;
      restarted = 1'b0;
      x = mk(TIMEOUT, MAXC, 1'b1);
      if (k >= MAXC) c = 1'b0;
      if (k <= MAXC - 1 && c) restarted = 1'b1;
      else if (k <= MAXC - 1 && e) x = mk(ERROR, k + 1, 1'b1);
      else if (k <= MAXC - 1 && h) x = mk(HALTED, k + 1, 1'b0);
      if (!restarted) sb.push_back(x);
      repeat (k) @(posedge clk);
      #1;
      err = e; halt = h; clr = c;
      @(posedge clk); #1;
      err = 1'b0; halt = 1'b0; clr = 1'b0;
      if (restarted) begin
         chk({tag, "_restart_state"}, 32'(state), 32'(RST_HOLD));
         chk({tag, "_restart_cnt"}, cycle_cnt, 0);
         wait_run(tag);
      end else begin
         wait_done(tag);
         repeat (20) @(posedge clk);
         #1;
         chk({tag, "_frozen"}, cycle_cnt, x.cnt);
         restart(tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'(RST_HOLD));
      chk("rst_core_rst", 32'(core_rst), 1);
      chk("rst_core_en", 32'(core_en), 0);
      chk("rst_cnt", cycle_cnt, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fail", 32'(fail), 0);
      release_seq("rel");

      run_one("halt", 10, 1'b0, 1'b1, 1'b0);
      run_one("errhalt", 5, 1'b1, 1'b1, 1'b0);
      run_one("timeout", MAXC + 3, 1'b0, 1'b0, 1'b0);
      run_one("last_err", MAXC - 1, 1'b1, 1'b0, 1'b0);
      run_one("clr_run", 4, 1'b1, 1'b1, 1'b1);

      // clr out of ERROR, with err/halt held high during the hold phase
      sb.push_back(mk(ERROR, 1, 1'b1));
      #1 err = 1'b1;
      @(posedge clk); #1;
      err = 1'b0;
      wait_done("clr_err");
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; err = 1'b1; halt = 1'b1;
      chk("clr_err_state", 32'(state), 32'(RST_HOLD));
      chk("clr_err_cnt", cycle_cnt, 0);
      chk("clr_err_done", 32'(done), 0);
      @(posedge clk); #1;
      chk("clr_err_hold", 32'(state), 32'(RST_HOLD));
      @(posedge clk); #1;
      chk("clr_err_run", 32'(state), 32'(RUN));
      err = 1'b0; halt = 1'b0;
      @(posedge clk); #1;
      chk("clr_err_run2", 32'(state), 32'(RUN));
      chk("clr_err_cnt2", cycle_cnt, 1);

      // asynchronous reset between edges
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_core_rst", 32'(core_rst), 1);
      chk("async_core_en", 32'(core_en), 0);
      chk("async_cnt", cycle_cnt, 0);
      chk("async_state", 32'(state), 32'(RST_HOLD));
      chk("async_done", 32'(done), 0);
      @(posedge clk); #1;
      release_seq("rel2");

      for (int i = 0; i < 30; i++) begin
         run_one("rnd", int'($urandom_range(0, MAXC + 4)), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      end

      repeat (2) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
